// File: rtl/chirp_sequencer.sv
// Stepped linear chirp (FMCW ramp) sequencer driving the phase_gen frequency word.
// Runs N chirps of latched start/stop/step/dwell with an idle gap between them.
module chirp_sequencer #(
    parameter int FW = 10,
    parameter int DW = 16,
    parameter int NW = 8
) (
    input  logic          aclk,
    input  logic          aresetn,
    input  logic          start,
    input  logic          abort,
    input  logic [FW-1:0] f_start,
    input  logic [FW-1:0] f_stop,
    input  logic [FW-1:0] f_step,
    input  logic [DW-1:0] dwell,
    input  logic [DW-1:0] gap,
    input  logic [NW-1:0] n_chirps,
    output logic [FW-1:0] freq,
    output logic          freq_vld,
    output logic          chirp_sof,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_GAP} state_t;

    state_t        r_state, w_state_nxt;
    logic [FW-1:0] r_fs, r_fe, r_st;
    logic [DW-1:0] r_dwell, r_gap;
    logic [NW-1:0] r_n;
    // One counter serves both the per-step dwell and the inter-chirp gap.
    logic [DW-1:0] r_cnt, w_cnt_nxt;
    logic [NW-1:0] r_chirps, w_chirps_nxt, w_chirps_inc;
    logic [FW-1:0] r_freq, w_freq_nxt;
    logic          r_vld, w_vld_nxt;
    logic          r_sof, w_sof_nxt;
    logic          r_busy, w_busy_nxt;
    logic          r_done, w_done_nxt;

    logic          w_latch, w_dwell_last, w_chirp_end, w_down;
    logic [FW:0]   w_up, w_dn;
    logic [FW-1:0] w_step_freq;

    assign w_latch      = (r_state == S_IDLE) && start && !abort;
    assign w_dwell_last = (r_dwell == '0) || (r_cnt == r_dwell - DW'(1));
    assign w_chirp_end  = (r_freq == r_fe) || (r_st == '0);
    assign w_down       = (r_fe < r_fs);
    assign w_chirps_inc = r_chirps + NW'(1);
    assign w_up         = {1'b0, r_freq} + {1'b0, r_st};
    assign w_dn         = {1'b0, r_freq} - {1'b0, r_st};

    // Clamp to f_stop on overshoot; the extra bit catches wrap past either end.
    always_comb begin
        if (w_down)
            w_step_freq = (w_dn[FW] || (w_dn[FW-1:0] < r_fe)) ? r_fe : w_dn[FW-1:0];
        else
            w_step_freq = (w_up > {1'b0, r_fe}) ? r_fe : w_up[FW-1:0];
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_chirps_nxt = r_chirps;
        w_freq_nxt   = r_freq;
        w_vld_nxt    = r_vld;
        w_sof_nxt    = 1'b0;
        w_busy_nxt   = r_busy;
        w_done_nxt   = 1'b0;
        if (abort) begin
            w_state_nxt  = S_IDLE;
            w_cnt_nxt    = '0;
            w_chirps_nxt = '0;
            w_freq_nxt   = '0;
            w_vld_nxt    = 1'b0;
            w_busy_nxt   = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        w_state_nxt  = S_SWEEP;
                        w_cnt_nxt    = '0;
                        w_chirps_nxt = '0;
                        w_freq_nxt   = f_start;
                        w_vld_nxt    = 1'b1;
                        w_sof_nxt    = 1'b1;
                        w_busy_nxt   = 1'b1;
                    end
                end
                S_SWEEP: begin
                    if (!w_dwell_last) begin
                        w_cnt_nxt = r_cnt + DW'(1);
                    end else begin
                        w_cnt_nxt = '0;
                        if (!w_chirp_end) begin
                            w_freq_nxt = w_step_freq;
                        end else begin
                            w_chirps_nxt = w_chirps_inc;
                            if ((r_n != '0) && (w_chirps_inc == r_n)) begin
                                w_state_nxt  = S_IDLE;
                                w_chirps_nxt = '0;
                                w_freq_nxt   = '0;
                                w_vld_nxt    = 1'b0;
                                w_busy_nxt   = 1'b0;
                                w_done_nxt   = 1'b1;
                            end else if (r_gap != '0) begin
                                w_state_nxt = S_GAP;
                                w_freq_nxt  = '0;
                                w_vld_nxt   = 1'b0;
                            end else begin
                                w_freq_nxt = r_fs;
                                w_sof_nxt  = 1'b1;
                            end
                        end
                    end
                end
                S_GAP: begin
                    if (r_cnt == r_gap - DW'(1)) begin
                        w_state_nxt = S_SWEEP;
                        w_cnt_nxt   = '0;
                        w_freq_nxt  = r_fs;
                        w_vld_nxt   = 1'b1;
                        w_sof_nxt   = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + DW'(1);
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_freq_nxt  = '0;
                    w_vld_nxt   = 1'b0;
                    w_busy_nxt  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_chirps <= '0;
            r_freq   <= '0;
            r_vld    <= 1'b0;
            r_sof    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_chirps <= w_chirps_nxt;
            r_freq   <= w_freq_nxt;
            r_vld    <= w_vld_nxt;
            r_sof    <= w_sof_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
        end
    end

    // Configuration is captured only on an accepted start.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_fs    <= '0;
            r_fe    <= '0;
            r_st    <= '0;
            r_dwell <= '0;
            r_gap   <= '0;
            r_n     <= '0;
        end else if (w_latch) begin
            r_fs    <= f_start;
            r_fe    <= f_stop;
            r_st    <= f_step;
            r_dwell <= dwell;
            r_gap   <= gap;
            r_n     <= n_chirps;
        end
    end

    assign freq      = r_freq;
    assign freq_vld  = r_vld;
    assign chirp_sof = r_sof;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_chirp_sequencer.sv
// Scoreboard bench for chirp_sequencer: per-cycle expected outputs are queued when a
// sequence is launched and compared on the falling edge.
module tb_chirp_sequencer;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b1;
    logic        start = 1'b0, abort = 1'b0;
    logic [9:0]  f_start = '0, f_stop = '0, f_step = '0;
    logic [15:0] dwell = '0, gap = '0;
    logic [7:0]  n_chirps = '0;
    logic [9:0]  freq;
    logic        freq_vld, chirp_sof, busy, done;

    // Packed observation: {freq, freq_vld, chirp_sof, busy, done}
    logic [13:0] sb[$];
    logic [13:0] exp_v, obs;
    int checks = 0;
    int errors = 0;

    chirp_sequencer dut (
        .aclk(aclk), .aresetn(aresetn), .start(start), .abort(abort),
        .f_start(f_start), .f_stop(f_stop), .f_step(f_step),
        .dwell(dwell), .gap(gap), .n_chirps(n_chirps),
        .freq(freq), .freq_vld(freq_vld), .chirp_sof(chirp_sof),
        .busy(busy), .done(done)
    );

    always #5 aclk = ~aclk;

    assign obs = {freq, freq_vld, chirp_sof, busy, done};

    // Reference model: queue m chirps (plus gaps or the done cycle).
    task automatic push_seq(input int fs, input int fe, input int st, input int dw,
                            input int gp, input int n, input int m);
        int  dwe;
        int  f;
        bit  first;
        dwe = (dw == 0) ? 1 : dw;
        for (int k = 1; k <= m; k++) begin
            f = fs;
            first = 1'b1;
            while (1) begin
                for (int d = 0; d < dwe; d++) begin
                    sb.push_back({f[9:0], 1'b1, first, 1'b1, 1'b0});
                    first = 1'b0;
                end
                if (f == fe || st == 0) break;
                if (fe >= fs) begin
                    f = f + st;
                    if (f > fe) f = fe;
                end else begin
                    f = f - st;
                    if (f < fe) f = fe;
                end
            end
            if (n != 0 && k == n) sb.push_back(14'h1);
            else for (int g = 0; g < gp; g++) sb.push_back(14'h2);
        end
    endtask

    task automatic start_seq(input int fs, input int fe, input int st, input int dw,
                             input int gp, input int n);
        @(negedge aclk);
        f_start = 10'(fs); f_stop = 10'(fe); f_step = 10'(st);
        dwell = 16'(dw); gap = 16'(gp); n_chirps = 8'(n);
        start = 1'b1;
        @(posedge aclk);
        #1 start = 1'b0;
    endtask

    task automatic test_reset;
        #2 aresetn = 1'b0;
        #1;
        checks++;
        if (obs !== 14'h0) begin
            errors++;
            $display("FAIL reset_async: got %h want %h", obs, 14'h0);
        end
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        checks++;
        if (obs !== 14'h0) begin
            errors++;
            $display("FAIL reset_hold: got %h want %h", obs, 14'h0);
        end
        aresetn = 1'b1;
        sb.push_back(14'h0);
        sb.push_back(14'h0);
        while (sb.size() > 0) begin
            @(negedge aclk);
            exp_v = sb.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL reset_idle: got %h want %h", obs, exp_v);
            end
        end
    endtask

    task automatic test_basic;
        push_seq(10, 14, 2, 3, 2, 2, 2);
        sb.push_back(14'h0);
        start_seq(10, 14, 2, 3, 2, 2);
        for (int c = 1; sb.size() > 0; c++) begin
            @(negedge aclk);
            exp_v = sb.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL basic c%0d: got %h want %h", c, obs, exp_v);
            end
        end
    endtask

    task automatic test_overshoot;
        sb.push_back({10'd10, 4'b1110});
        sb.push_back({10'd14, 4'b1010});
        sb.push_back({10'd15, 4'b1010});
        sb.push_back(14'h1);
        sb.push_back(14'h0);
        start_seq(10, 15, 4, 1, 0, 1);
        for (int c = 1; sb.size() > 0; c++) begin
            @(negedge aclk);
            exp_v = sb.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL overshoot c%0d: got %h want %h", c, obs, exp_v);
            end
        end
    endtask

    task automatic test_down;
        push_seq(20, 12, 5, 1, 0, 2, 2);
        sb.push_back(14'h0);
        start_seq(20, 12, 5, 1, 0, 2);
        for (int c = 1; sb.size() > 0; c++) begin
            @(negedge aclk);
            exp_v = sb.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL down c%0d: got %h want %h", c, obs, exp_v);
            end
        end
    endtask

    task automatic test_back_to_back;
        push_seq(33, 40, 0, 0, 0, 3, 3);
        sb.push_back(14'h0);
        start_seq(33, 40, 0, 0, 0, 3);
        for (int c = 1; sb.size() > 0; c++) begin
            @(negedge aclk);
            exp_v = sb.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL back_to_back c%0d: got %h want %h", c, obs, exp_v);
            end
        end
    endtask

    task automatic test_abort;
        push_seq(100, 103, 1, 2, 1, 0, 2);
        start_seq(100, 103, 1, 2, 1, 0);
        for (int c = 1; c <= 12; c++) begin
            @(negedge aclk);
            exp_v = sb.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL abort_run c%0d: got %h want %h", c, obs, exp_v);
            end
            // A start while busy, with different inputs, must change nothing.
            if (c == 3) begin
                start = 1'b1; f_start = 10'd500; f_stop = 10'd900; dwell = 16'd7;
            end
            if (c == 4) start = 1'b0;
        end
        sb.delete();
        abort = 1'b1;
        @(posedge aclk);
        #1 abort = 1'b0;
        repeat (3) sb.push_back(14'h0);
        for (int c = 1; sb.size() > 0; c++) begin
            @(negedge aclk);
            exp_v = sb.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL abort_idle c%0d: got %h want %h", c, obs, exp_v);
            end
        end
        start = 1'b1;
        abort = 1'b1;
        @(posedge aclk);
        #1 begin start = 1'b0; abort = 1'b0; end
        repeat (2) sb.push_back(14'h0);
        for (int c = 1; sb.size() > 0; c++) begin
            @(negedge aclk);
            exp_v = sb.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL abort_start c%0d: got %h want %h", c, obs, exp_v);
            end
        end
        push_seq(7, 9, 1, 1, 0, 1, 1);
        sb.push_back(14'h0);
        start_seq(7, 9, 1, 1, 0, 1);
        for (int c = 1; sb.size() > 0; c++) begin
            @(negedge aclk);
            exp_v = sb.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL abort_restart c%0d: got %h want %h", c, obs, exp_v);
            end
        end
    endtask

    task automatic test_async_reset;
        push_seq(50, 52, 1, 1, 5, 2, 1);
        start_seq(50, 52, 1, 1, 5, 2);
        for (int c = 1; c <= 5; c++) begin
            @(negedge aclk);
            exp_v = sb.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL gap_run c%0d: got %h want %h", c, obs, exp_v);
            end
        end
        sb.delete();
        #2 aresetn = 1'b0;
        #1;
        checks++;
        if (obs !== 14'h0) begin
            errors++;
            $display("FAIL gap_reset: got %h want %h", obs, 14'h0);
        end
        @(negedge aclk);
        aresetn = 1'b1;
        repeat (3) sb.push_back(14'h0);
        for (int c = 1; sb.size() > 0; c++) begin
            @(negedge aclk);
            exp_v = sb.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL post_reset c%0d: got %h want %h", c, obs, exp_v);
            end
        end
        push_seq(60, 61, 1, 2, 0, 1, 1);
        sb.push_back(14'h0);
        start_seq(60, 61, 1, 2, 0, 1);
        for (int c = 1; sb.size() > 0; c++) begin
            @(negedge aclk);
            exp_v = sb.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL post_reset_run c%0d: got %h want %h", c, obs, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overshoot();
        test_down();
        test_back_to_back();
        test_abort();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
